// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared constants and FSM state type for the scoreboard
//                binary-to-BCD converter.
//  Revision    : 1.0  initial release
// ============================================================================
package snake_pkg;

    // Largest value that fits on four decimal digits
    localparam int SAT        = 9999;
    // Number of double-dabble iterations, the bit width of SAT
    localparam int DAB_W      = 14;
    // Decimal digits per displayed value
    localparam int BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_STORE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/score_bcd_converter_dabble_step.sv
`default_nettype none
// ============================================================================
//  Module      : dabble_step
//  Description : One shift-and-add-3 iteration. Every BCD nibble that is >= 5
//                gets 3 added, then the vector shifts left by one bit and
//                takes the next binary MSB into bit 0.
//  Revision    : 1.0  initial release
// ============================================================================
module dabble_step
    import snake_pkg::*;
(
    input  logic [4*BCD_DIGITS-1:0] bcd,
    input  logic                    msb_in,
    output logic [4*BCD_DIGITS-1:0] bcd_next
);

    localparam int BCD_W = 4 * BCD_DIGITS;

    // Adjusted lower nibbles; their bit 3 feeds the next nibble after the shift
    logic [BCD_W-5:0] w_adj_low;
    // Only the low three bits of the top nibble survive the shift
    logic [2:0]       w_adj_top;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS - 1; gi++) begin : g_nib
            assign w_adj_low[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5)
                                        ? bcd[4*gi +: 4] + 4'd3
                                        : bcd[4*gi +: 4];
        end
    endgenerate

    // The top-nibble sum is only needed modulo 8
    assign w_adj_top = bcd[BCD_W-2 -: 3]
                     + ((bcd[BCD_W-1 -: 4] >= 4'd5) ? 3'd3 : 3'd0);

    assign bcd_next = {w_adj_top, w_adj_low, msb_in};

endmodule
`default_nettype wire

// File: rtl/score_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : score_bcd_converter
//  Description : Sequential binary-to-BCD converter for the score and the
//                high score. A single double-dabble engine converts score,
//                then high score, whenever either snapshot differs from the
//                last converted pair. Values above SAT display as SAT and
//                raise the matching overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module score_bcd_converter
    import snake_pkg::*;
#(
    parameter int BIN_W = 20,
    parameter int SAT   = snake_pkg::SAT,
    parameter int DAB_W = snake_pkg::DAB_W
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    input  logic [BIN_W-1:0] score,
    input  logic [BIN_W-1:0] high_score,
    output logic [3:0]       unit,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands,
    output logic [3:0]       h_unit,
    output logic [3:0]       h_tens,
    output logic [3:0]       h_hundreds,
    output logic [3:0]       h_thousands,
    output logic             score_ovf,
    output logic             high_ovf,
    output logic             busy,
    output logic             done
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(DAB_W);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DAB_W - 1);
    localparam logic [BIN_W-1:0] c_sat_bin  = BIN_W'(SAT);
    localparam logic [DAB_W-1:0] c_sat_dab  = DAB_W'(SAT);

    state_t             state_q,     state_d;
    logic               sel_q,       sel_d;
    logic [BIN_W-1:0]   snap_s_q,    snap_s_d;
    logic [BIN_W-1:0]   snap_h_q,    snap_h_d;
    logic [BIN_W-1:0]   last_s_q,    last_s_d;
    logic [BIN_W-1:0]   last_h_q,    last_h_d;
    logic [DAB_W-1:0]   bin_q,       bin_d;
    logic [BCD_W-1:0]   bcd_q,       bcd_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               ovf_pend_q,  ovf_pend_d;
    logic [BCD_W-1:0]   s_dig_q,     s_dig_d;
    logic [BCD_W-1:0]   h_dig_q,     h_dig_d;
    logic               score_ovf_q, score_ovf_d;
    logic               high_ovf_q,  high_ovf_d;
    logic               done_q,      done_d;

    logic [BIN_W-1:0]   w_operand;
    logic               w_op_ovf;
    logic [DAB_W-1:0]   w_op_clamped;
    logic               w_changed;
    logic [BCD_W-1:0]   w_bcd_step;

    // Operand selection and clamping feed the LOAD state
    assign w_operand    = sel_q ? snap_h_q : snap_s_q;
    assign w_op_ovf     = (w_operand > c_sat_bin);
    assign w_op_clamped = w_op_ovf ? c_sat_dab : w_operand[DAB_W-1:0];
    assign w_changed    = (snap_s_q != last_s_q) || (snap_h_q != last_h_q);

    dabble_step u_dabble_step (
        .bcd      (bcd_q),
        .msb_in   (bin_q[DAB_W-1]),
        .bcd_next (w_bcd_step)
    );

    // Next-state and datapath logic of the conversion sequencer
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        snap_s_d    = snap_s_q;
        snap_h_d    = snap_h_q;
        last_s_d    = last_s_q;
        last_h_d    = last_h_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        s_dig_d     = s_dig_q;
        h_dig_d     = h_dig_q;
        score_ovf_d = score_ovf_q;
        high_ovf_d  = high_ovf_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Track the inputs only while idle so a running conversion
                // works on a stable pair
                snap_s_d = score;
                snap_h_d = high_score;
                if (w_changed) begin
                    sel_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bin_d      = w_op_clamped;
                bcd_d      = '0;
                cnt_d      = '0;
                ovf_pend_d = w_op_ovf;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                bcd_d = w_bcd_step;
                bin_d = {bin_q[DAB_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == c_cnt_last) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                if (!sel_q) begin
                    s_dig_d     = bcd_q;
                    score_ovf_d = ovf_pend_q;
                    sel_d       = 1'b1;
                    state_d     = S_LOAD;
                end else begin
                    h_dig_d    = bcd_q;
                    high_ovf_d = ovf_pend_q;
                    last_s_d   = snap_s_q;
                    last_h_d   = snap_h_q;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and data registers; reset aborts any conversion in progress
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            snap_s_q    <= '0;
            snap_h_q    <= '0;
            last_s_q    <= '0;
            last_h_q    <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            s_dig_q     <= '0;
            h_dig_q     <= '0;
            score_ovf_q <= 1'b0;
            high_ovf_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            snap_s_q    <= snap_s_d;
            snap_h_q    <= snap_h_d;
            last_s_q    <= last_s_d;
            last_h_q    <= last_h_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            s_dig_q     <= s_dig_d;
            h_dig_q     <= h_dig_d;
            score_ovf_q <= score_ovf_d;
            high_ovf_q  <= high_ovf_d;
            done_q      <= done_d;
        end
    end

    assign unit        = s_dig_q[3:0];
    assign tens        = s_dig_q[7:4];
    assign hundreds    = s_dig_q[11:8];
    assign thousands   = s_dig_q[15:12];
    assign h_unit      = h_dig_q[3:0];
    assign h_tens      = h_dig_q[7:4];
    assign h_hundreds  = h_dig_q[11:8];
    assign h_thousands = h_dig_q[15:12];
    assign score_ovf   = score_ovf_q;
    assign high_ovf    = high_ovf_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_bcd_converter
//  Description : Self-checking bench for score_bcd_converter: directed
//                latency/corner sequences, a vector table and a random sweep
//                against a decimal reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_score_bcd_converter;

    logic        clock_100Mhz = 1'b0;
    logic        reset        = 1'b1;
    logic [19:0] score        = '0;
    logic [19:0] high_score   = '0;
    logic [3:0]  unit, tens, hundreds, thousands;
    logic [3:0]  h_unit, h_tens, h_hundreds, h_thousands;
    logic        score_ovf, high_ovf, busy, done;

    int total = 0;
    int bad   = 0;

    score_bcd_converter dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .score        (score),
        .high_score   (high_score),
        .unit         (unit),
        .tens         (tens),
        .hundreds     (hundreds),
        .thousands    (thousands),
        .h_unit       (h_unit),
        .h_tens       (h_tens),
        .h_hundreds   (h_hundreds),
        .h_thousands  (h_thousands),
        .score_ovf    (score_ovf),
        .high_ovf     (high_ovf),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    typedef struct {
        int          s;
        int          h;
        logic [15:0] exp_s;
        logic [15:0] exp_h;
        logic        exp_sovf;
        logic        exp_hovf;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] s_digits();
        return {thousands, hundreds, tens, unit};
    endfunction

    function automatic logic [15:0] h_digits();
        return {h_thousands, h_hundreds, h_tens, h_unit};
    endfunction

    // Reference: clamp then split into decimal digits
    function automatic logic [15:0] ref_bcd(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic bit nibbles_ok(input logic [15:0] d);
        bit ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (d[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for a done pulse, at most max_cyc negedges
    task automatic wait_done(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock_100Mhz);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit got;
        int busy_cnt;
        int done_cnt;
        int done_at;
        int first_busy;
        int ps, ph, rs, rh;

        vecs[0] = '{1234,    0,     16'h1234, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{9999,    10000, 16'h9999, 16'h9999, 1'b0, 1'b1};
        vecs[2] = '{10000,   9999,  16'h9999, 16'h9999, 1'b1, 1'b0};
        vecs[3] = '{0,       9998,  16'h0000, 16'h9998, 1'b0, 1'b0};
        vecs[4] = '{1048575, 1,     16'h9999, 16'h0001, 1'b1, 1'b0};
        vecs[5] = '{1000,    999,   16'h1000, 16'h0999, 1'b0, 1'b0};
        vecs[6] = '{9,       10,    16'h0009, 16'h0010, 1'b0, 1'b0};
        vecs[7] = '{8888,    12345, 16'h8888, 16'h9999, 1'b0, 1'b1};

        // ---- reset state and quiet idle with zero inputs ----
        repeat (3) @(negedge clock_100Mhz);
        check("reset_s_digits", 32'(s_digits()), 32'h0);
        check("reset_h_digits", 32'(h_digits()), 32'h0);
        check("reset_flags", {28'h0, score_ovf, high_ovf, busy, done}, 32'h0);
        reset = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock_100Mhz);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("idle_busy_count", 32'(busy_cnt), 32'd0);
        check("idle_done_count", 32'(done_cnt), 32'd0);

        // ---- 1234 / 0: exact latency of digits, busy and done ----
        score = 20'd1234;
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        first_busy = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock_100Mhz);
            @(negedge clock_100Mhz);
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = k;
            end
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 17) check("lat_s_before_store", 32'(s_digits()), 32'h0);
            if (k == 18) check("lat_s_visible", 32'(s_digits()), 32'h1234);
            if (k == 34) check("lat_h_digits", 32'(h_digits()), 32'h0);
        end
        check("lat_busy_count", 32'(busy_cnt), 32'd32);
        check("lat_busy_first", 32'(first_busy), 32'd2);
        check("lat_done_count", 32'(done_cnt), 32'd1);
        check("lat_done_cycle", 32'(done_at), 32'd34);

        // ---- 57 -> 58 change in the middle of a conversion ----
        score = 20'd57;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock_100Mhz);
            @(negedge clock_100Mhz);
        end
        score = 20'd58;
        wait_done(120, got);
        check("chg_first_done", 32'(got), 32'd1);
        check("chg_first_digits", 32'(s_digits()), 32'h0057);
        wait_done(120, got);
        check("chg_second_done", 32'(got), 32'd1);
        check("chg_second_digits", 32'(s_digits()), 32'h0058);

        // ---- reset in the middle of converting 4321 ----
        score = 20'd4321;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clock_100Mhz);
            @(negedge clock_100Mhz);
        end
        reset = 1'b1;
        #1;
        check("rst_mid_s_digits", 32'(s_digits()), 32'h0);
        check("rst_mid_flags", {30'h0, busy, done}, 32'h0);
        @(negedge clock_100Mhz);
        reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clock_100Mhz);
            @(negedge clock_100Mhz);
            if (k == 17) check("rst_restart_before", 32'(s_digits()), 32'h0);
            if (k == 18) check("rst_restart_digits", 32'(s_digits()), 32'h4321);
        end
        wait_done(120, got);
        check("rst_restart_done", 32'(got), 32'd1);

        // ---- table of fixed vectors ----
        for (int i = 0; i < 8; i++) begin
            score      = 20'(vecs[i].s);
            high_score = 20'(vecs[i].h);
            wait_done(120, got);
            check($sformatf("vec%0d_done", i), 32'(got), 32'd1);
            check($sformatf("vec%0d_s", i), 32'(s_digits()), 32'(vecs[i].exp_s));
            check($sformatf("vec%0d_h", i), 32'(h_digits()), 32'(vecs[i].exp_h));
            check($sformatf("vec%0d_ovf", i), {30'h0, score_ovf, high_ovf},
                  {30'h0, vecs[i].exp_sovf, vecs[i].exp_hovf});
        end

        // ---- random sweep against the decimal model ----
        ps = vecs[7].s;
        ph = vecs[7].h;
        for (int i = 0; i < 1000; i++) begin
            rs = int'($urandom_range(0, 1048575));
            rh = int'($urandom_range(0, 1048575));
            if (i % 4 == 0) rs = int'($urandom_range(0, 10010));
            if (i % 4 == 1) rh = int'($urandom_range(9990, 10010));
            if (rs == ps && rh == ph) rs = rs ^ 1;
            score      = 20'(rs);
            high_score = 20'(rh);
            ps = rs;
            ph = rh;
            wait_done(120, got);
            check("rnd_done", 32'(got), 32'd1);
            check("rnd_nibbles", 32'({nibbles_ok(s_digits()), nibbles_ok(h_digits())}), 32'd3);
            check("rnd_s", 32'(s_digits()), 32'(ref_bcd(rs)));
            check("rnd_h", 32'(h_digits()), 32'(ref_bcd(rh)));
            check("rnd_ovf", {30'h0, score_ovf, high_ovf},
                  {30'h0, (rs > 9999), (rh > 9999)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
